ps2_mouse_init_ctrl: RTL and testbench
======================================

Name: ps2_mouse_init_ctrl

Overview:
Configuration sequencer placed between the PS/2 transceiver and the mouse packet assembler. It resets the mouse and programs sample rate and resolution. It then enables streaming, checking every acknowledge, retrying on resend or timeout, and flagging errors. Once complete, it hands the receive stream to the packet assembler by asserting ready.

Parameters:
SAMPLE_RATE, 8'h64, rate byte sent after F3 (100 samples/s)
RESOLUTION, 8'h02, resolution byte sent after E8 (4 counts/mm)
ACK_TIMEOUT_CYC, 5_000_000, cycles to wait for a response byte (100 ms at 50 MHz)
BAT_TIMEOUT_CYC, 50_000_000, cycles to wait for the AA byte after FF (1 s)
MAX_RETRY, 3, resends per byte before error

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; restarts the sequence from step 0
tx_done_tick  in  1  transceiver finished sending a byte
rx_done_tick  in  1  transceiver received a byte
rx_data  in  8  received byte, valid with rx_done_tick
wr_ps2  out  1  one-cycle send strobe to the transceiver
tx_data  out  8  byte to send, registered, stable from wr_ps2 until tx_done_tick
busy  out  1  sequence in progress
ready  out  1  level; stream mode active, packet assembler may consume rx bytes
error  out  1  sticky; cleared only by start or reset
err_code  out  2  01 timeout, 10 nack (FC, or FE with retries exhausted), 11 bad BAT/ID
wheel_en  out  1  wheel protocol active (see Optional Feature)

Behaviour:
- Reset values: wr_ps2=0, tx_data=00, busy=0, ready=0, error=0, err_code=00, wheel_en=0, state=IDLE, step=0, retry=0.
- Auto-start: the controller leaves IDLE on the first clock after reset deasserts. start has the same effect at any time, including mid-sequence and in DONE or ERR. A restart clears ready, error, retry and step.
- Command sequence (base): FF, F3, SAMPLE_RATE, E8, RESOLUTION, F4. Every byte expects FA. FF additionally expects AA, then 00.
- States:
  - SEND: wr_ps2=1 for exactly 1 cycle; tx_data is loaded from the step table in the same cycle. Go to WAIT_TX.
  - WAIT_TX: wait for tx_done_tick, then go to WAIT_ACK and clear the timer. rx ticks are ignored here.
  - WAIT_ACK:
    - FA: go to WAIT_BAT if the step is FF, else go to NEXT.
    - FE: retry++; return to SEND with the same byte, or go to ERR(10) if retry==MAX_RETRY.
    - FC or any other byte: go to ERR(10).
    - Timeout: handled like FE, but exhaustion goes to ERR(01).
  - WAIT_BAT: wait for AA (timer uses BAT_TIMEOUT_CYC), then go to WAIT_ID. FC or any other byte goes to ERR(11). Timeout goes to ERR(01) with no retry.
  - WAIT_ID: 00 goes to NEXT. Any other byte goes to ERR(11). Timeout goes to ERR(01).
  - NEXT: step++ and retry=0. Go to SEND, or to DONE after the last step. This state takes 1 cycle.
  - DONE: ready=1, busy=0. rx ticks are ignored by the controller.
  - ERR: error=1 with err_code latched, busy=0, ready=0. The controller holds here until start.
- busy=1 in every state except IDLE, DONE and ERR.
- The timer clears on entry to every wait state. Timeout fires when the count equals the limit minus 1.
- Same-cycle rx_done_tick and timeout: rx_done_tick wins.
- tx_done_tick outside WAIT_TX is ignored.
- Reset asserted mid-operation returns all outputs to reset values immediately (async). The sequence restarts after release.
- Latency from auto-start to ready, with an ideal device: 6 sends + 8 received bytes + 1 cycle per state transition.

Optional Feature:
PS2_INTELLIMOUSE_EN
- Defined: after RESOLUTION and before F4, insert the sequence F3 C8, F3 64, F3 50, F2. Each of these bytes expects FA. After the FA to F2, one ID byte follows, with no timeout retry:
  - 03: set wheel_en=1.
  - 00: set wheel_en=0 and continue; this is not an error.
  - Any other byte: ERR(11).
- Not defined: the base sequence only, and wheel_en is tied 0.

Decomposition:
- Package ps2_mouse_pkg holds:
  - command codes (FF, F3, E8, F4, F2)
  - response codes (FA, FE, FC, AA)
  - state encoding
  - err_code values
  - the step-table entry layout (byte, expects-BAT flag)
- One sub-module, ps2_timeout_timer: clear/enable/limit-select inputs and a timeout pulse output.

Test Plan:
- Ideal device answers FA to every byte, plus AA,00 after FF → tx bytes FF,F3,64,E8,02,F4 in order; ready=1, busy=0, error=0.
- Device answers FE twice to E8, then FA → E8 is sent 3 times in total; the sequence completes with ready=1.
- Device is silent after F3 → after 4 timeouts of ACK_TIMEOUT_CYC, error=1, err_code=01, ready=0.
- BAT returns FC instead of AA → error=1, err_code=11; then pulse start with an ideal device → error clears and ready=1.
- Reset asserted while waiting for the ack to E8, then released → outputs are at reset values during reset, and the sequence restarts with FF.
- With PS2_INTELLIMOUSE_EN defined, the device returns 03 after F2 → the knock bytes are seen on tx_data, wheel_en=1, and ready=1 after F4/FA.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg
//   Shared definitions for the PS/2 mouse initialisation sequencer:
//   command/response byte codes, FSM state encoding, err_code values,
//   the step-table entry layout and the step-table lookup function.
//   Optional feature macro: PS2_INTELLIMOUSE_EN (adds the wheel knock
//   sequence F3 C8, F3 64, F3 50, F2 before F4).
package ps2_mouse_pkg;

    // Host-to-mouse commands
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_SET_RES  = 8'hE8;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_GET_ID   = 8'hF2;

    // Mouse-to-host responses
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ERROR    = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] ID_STD       = 8'h00;
    localparam logic [7:0] ID_WHEEL     = 8'h03;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;
    localparam logic [1:0] ERR_BAD_ID  = 2'b11;

    // One step of the command sequence: byte to send, whether the FA is
    // followed by a BAT (AA then 00), and whether it is followed by a
    // device ID byte (wheel detection).
    typedef struct packed {
        logic [7:0] cmd;
        logic       exp_bat;
        logic       exp_id;
    } step_t;

    localparam int unsigned STEP_W = 4;
`ifdef PS2_INTELLIMOUSE_EN
    localparam int unsigned N_STEPS = 13;
`else
    localparam int unsigned N_STEPS = 6;
`endif

    function automatic step_t get_step(input logic [STEP_W-1:0] idx,
                                       input logic [7:0]        rate,
                                       input logic [7:0]        res);
        step_t s;
        s = '{CMD_ENABLE, 1'b0, 1'b0};
        case (idx)
            4'd0:  s = '{CMD_RESET,    1'b1, 1'b0};
            4'd1:  s = '{CMD_SET_RATE, 1'b0, 1'b0};
            4'd2:  s = '{rate,         1'b0, 1'b0};
            4'd3:  s = '{CMD_SET_RES,  1'b0, 1'b0};
            4'd4:  s = '{res,          1'b0, 1'b0};
`ifdef PS2_INTELLIMOUSE_EN
            4'd5:  s = '{CMD_SET_RATE, 1'b0, 1'b0};
            4'd6:  s = '{8'hC8,        1'b0, 1'b0};
            4'd7:  s = '{CMD_SET_RATE, 1'b0, 1'b0};
            4'd8:  s = '{8'h64,        1'b0, 1'b0};
            4'd9:  s = '{CMD_SET_RATE, 1'b0, 1'b0};
            4'd10: s = '{8'h50,        1'b0, 1'b0};
            4'd11: s = '{CMD_GET_ID,   1'b0, 1'b1};
`endif
            default: s = '{CMD_ENABLE, 1'b0, 1'b0};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// ps2_timeout_timer
//   Response timer for the PS/2 initialisation sequencer.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     i_clr         synchronous clear of the count
//     i_en          count enable (controller is in a wait state)
//     i_sel_bat     1 selects BAT_TIMEOUT_CYC, 0 selects ACK_TIMEOUT_CYC
//     o_timeout     high while enabled and count equals limit-1
module ps2_timeout_timer #(
    parameter int unsigned ACK_TIMEOUT_CYC = 5_000_000,
    parameter int unsigned BAT_TIMEOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_sel_bat,
    output logic o_timeout
);

    localparam logic [31:0] ACK_LAST = 32'(ACK_TIMEOUT_CYC - 1);
    localparam logic [31:0] BAT_LAST = 32'(BAT_TIMEOUT_CYC - 1);

    logic [31:0] r_cnt;
    logic [31:0] w_last;
    logic        w_at_last;

    assign w_last    = i_sel_bat ? BAT_LAST : ACK_LAST;
    assign w_at_last = (r_cnt == w_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_last) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_timeout = i_en && w_at_last;

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// ps2_mouse_init_ctrl
//   Configuration sequencer between the PS/2 transceiver and the mouse
//   packet assembler: resets the mouse, sets sample rate and resolution,
//   enables streaming, checks each acknowledge, retries on resend/timeout.
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     start             pulse; restarts the sequence from step 0
//     tx_done_tick      transceiver finished sending a byte
//     rx_done_tick      transceiver received a byte (rx_data valid)
//     wr_ps2, tx_data   one-cycle send strobe and registered byte to send
//     busy              sequence in progress
//     ready             stream mode active
//     error, err_code   sticky error flag; 01 timeout, 10 nack, 11 bad BAT/ID
//     wheel_en          wheel protocol detected
//   Optional feature macro: PS2_INTELLIMOUSE_EN (wheel knock sequence).
module ps2_mouse_init_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter logic [7:0]  SAMPLE_RATE     = 8'h64,
    parameter logic [7:0]  RESOLUTION      = 8'h02,
    parameter int unsigned ACK_TIMEOUT_CYC = 5_000_000,
    parameter int unsigned BAT_TIMEOUT_CYC = 50_000_000,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tx_done_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       wr_ps2,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       ready,
    output logic       error,
    output logic [1:0] err_code,
    output logic       wheel_en
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);
    localparam logic [3:0]        RETRY_LIM = 4'(MAX_RETRY);

    state_t            r_state,  w_state_nx;
    logic [STEP_W-1:0] r_step,   w_step_nx;
    logic [3:0]        r_retry,  w_retry_nx;
    logic              r_wr,     w_wr_nx;
    logic [7:0]        r_tx,     w_tx_nx;
    logic              r_error,  w_error_nx;
    logic [1:0]        r_err,    w_err_nx;
    step_t             w_entry;
    logic              w_timeout;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic              w_tmr_bat;
`ifdef PS2_INTELLIMOUSE_EN
    logic              r_wheel,  w_wheel_nx;
`endif

    assign w_entry = get_step(r_step, SAMPLE_RATE, RESOLUTION);

    ps2_timeout_timer #(
        .ACK_TIMEOUT_CYC (ACK_TIMEOUT_CYC),
        .BAT_TIMEOUT_CYC (BAT_TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .i_sel_bat (w_tmr_bat),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_retry <= '0;
            r_wr    <= 1'b0;
            r_tx    <= '0;
            r_error <= 1'b0;
            r_err   <= ERR_NONE;
`ifdef PS2_INTELLIMOUSE_EN
            r_wheel <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_step  <= w_step_nx;
            r_retry <= w_retry_nx;
            r_wr    <= w_wr_nx;
            r_tx    <= w_tx_nx;
            r_error <= w_error_nx;
            r_err   <= w_err_nx;
`ifdef PS2_INTELLIMOUSE_EN
            r_wheel <= w_wheel_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        w_retry_nx = r_retry;
        w_wr_nx    = 1'b0;
        w_tx_nx    = r_tx;
        w_error_nx = r_error;
        w_err_nx   = r_err;
`ifdef PS2_INTELLIMOUSE_EN
        w_wheel_nx = r_wheel;
`endif

        case (r_state)
            ST_IDLE: w_state_nx = ST_SEND;

            ST_SEND: begin
                w_wr_nx    = 1'b1;
                w_tx_nx    = w_entry.cmd;
                w_state_nx = ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
                if (tx_done_tick) w_state_nx = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                // rx_done_tick is tested first so it wins over a same-cycle timeout
                if (rx_done_tick) begin
                    if (rx_data == RSP_ACK) begin
                        if (w_entry.exp_bat)     w_state_nx = ST_WAIT_BAT;
                        else if (w_entry.exp_id) w_state_nx = ST_WAIT_ID;
                        else                     w_state_nx = ST_NEXT;
                    end else if (rx_data == RSP_RESEND && r_retry != RETRY_LIM) begin
                        w_retry_nx = r_retry + 4'd1;
                        w_state_nx = ST_SEND;
                    end else begin
                        w_state_nx = ST_ERR;
                        w_error_nx = 1'b1;
                        w_err_nx   = ERR_NACK;
                    end
                end else if (w_timeout) begin
                    if (r_retry != RETRY_LIM) begin
                        w_retry_nx = r_retry + 4'd1;
                        w_state_nx = ST_SEND;
                    end else begin
                        w_state_nx = ST_ERR;
                        w_error_nx = 1'b1;
                        w_err_nx   = ERR_TIMEOUT;
                    end
                end
            end

            ST_WAIT_BAT: begin
                if (rx_done_tick) begin
                    if (rx_data == RSP_BAT_OK) begin
                        w_state_nx = ST_WAIT_ID;
                    end else begin
                        w_state_nx = ST_ERR;
                        w_error_nx = 1'b1;
                        w_err_nx   = ERR_BAD_ID;
                    end
                end else if (w_timeout) begin
                    w_state_nx = ST_ERR;
                    w_error_nx = 1'b1;
                    w_err_nx   = ERR_TIMEOUT;
                end
            end

            ST_WAIT_ID: begin
                if (rx_done_tick) begin
`ifdef PS2_INTELLIMOUSE_EN
                    if (w_entry.exp_id && (rx_data == ID_WHEEL || rx_data == ID_STD)) begin
                        w_wheel_nx = (rx_data == ID_WHEEL);
                        w_state_nx = ST_NEXT;
                    end else
`endif
                    if (rx_data == ID_STD) begin
                        w_state_nx = ST_NEXT;
                    end else begin
                        w_state_nx = ST_ERR;
                        w_error_nx = 1'b1;
                        w_err_nx   = ERR_BAD_ID;
                    end
                end else if (w_timeout) begin
                    w_state_nx = ST_ERR;
                    w_error_nx = 1'b1;
                    w_err_nx   = ERR_TIMEOUT;
                end
            end

            ST_NEXT: begin
                w_retry_nx = '0;
                if (r_step == LAST_STEP) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_step_nx  = r_step + 1'b1;
                    w_state_nx = ST_SEND;
                end
            end

            ST_DONE: w_state_nx = ST_DONE;
            ST_ERR:  w_state_nx = ST_ERR;
            default: w_state_nx = ST_IDLE;
        endcase

        if (start) begin
            w_state_nx = ST_SEND;
            w_step_nx  = '0;
            w_retry_nx = '0;
            w_wr_nx    = 1'b0;
            w_error_nx = 1'b0;
            w_err_nx   = ERR_NONE;
`ifdef PS2_INTELLIMOUSE_EN
            w_wheel_nx = 1'b0;
`endif
        end
    end

    // Every state change (including a resend back through SEND) clears the
    // timer, so each wait state starts counting from zero.
    assign w_tmr_clr = (w_state_nx != r_state) || start;
    assign w_tmr_en  = (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_BAT) ||
                       (r_state == ST_WAIT_ID);
    assign w_tmr_bat = (r_state == ST_WAIT_BAT);

    assign wr_ps2   = r_wr;
    assign tx_data  = r_tx;
    assign busy     = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);
    assign ready    = (r_state == ST_DONE);
    assign error    = r_error;
    assign err_code = r_err;
`ifdef PS2_INTELLIMOUSE_EN
    assign wheel_en = r_wheel;
`else
    assign wheel_en = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// tb_ps2_mouse_init_ctrl
//   Self-checking bench for ps2_mouse_init_ctrl. Expected tx bytes are
//   queued as each command is served; a monitor pops and compares on
//   every wr_ps2 strobe. Honours PS2_INTELLIMOUSE_EN.
module tb_ps2_mouse_init_ctrl;

    localparam int unsigned ACK_CYC = 50;
    localparam int unsigned BAT_CYC = 80;
    localparam int unsigned TXD     = 2;
`ifdef PS2_INTELLIMOUSE_EN
    localparam logic EXP_WHEEL = 1'b1;
`else
    localparam logic EXP_WHEEL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       tx_done_tick = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       wr_ps2;
    logic [7:0] tx_data;
    logic       busy;
    logic       ready;
    logic       error;
    logic [1:0] err_code;
    logic       wheel_en;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    logic        prev_wr = 1'b0;

    ps2_mouse_init_ctrl #(
        .SAMPLE_RATE     (8'h64),
        .RESOLUTION      (8'h02),
        .ACK_TIMEOUT_CYC (ACK_CYC),
        .BAT_TIMEOUT_CYC (BAT_CYC),
        .MAX_RETRY       (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tx_done_tick (tx_done_tick),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .wr_ps2       (wr_ps2),
        .tx_data      (tx_data),
        .busy         (busy),
        .ready        (ready),
        .error        (error),
        .err_code     (err_code),
        .wheel_en     (wheel_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every send strobe must match the next queued byte
    initial begin
        forever begin
            @(negedge clk);
            if (wr_ps2 === 1'b1) begin
                chk("wr_ps2_one_cycle", {31'd0, prev_wr}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %0h, expected no send", tx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("tx_data", {24'd0, tx_data}, {24'd0, mon_exp});
                end
            end
            prev_wr = wr_ps2;
        end
    end

    task automatic wait_wr(output int unsigned t);
        bit seen;
        seen = 1'b0;
        t = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (wr_ps2 === 1'b1) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_wr: got no wr_ps2 in 300 cycles, expected a send");
        end
    endtask

    task automatic pulse_tx_done();
        repeat (TXD) @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic serve(input logic [7:0] cmd, input int n,
                         input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        int unsigned t;
        exp_q.push_back(cmd);
        wait_wr(t);
        pulse_tx_done();
        if (n > 0) send_rx(r0);
        if (n > 1) send_rx(r1);
        if (n > 2) send_rx(r2);
    endtask

    task automatic run_ideal();
        serve(8'hFF, 3, 8'hFA, 8'hAA, 8'h00);
        serve(8'hF3, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'h64, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'hE8, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'h02, 1, 8'hFA, 8'h00, 8'h00);
`ifdef PS2_INTELLIMOUSE_EN
        serve(8'hF3, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'hC8, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'hF3, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'h64, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'hF3, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'h50, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'hF2, 2, 8'hFA, 8'h03, 8'h00);
`endif
        serve(8'hF4, 1, 8'hFA, 8'h00, 8'h00);
    endtask

    task automatic wait_end(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (ready === 1'b1 || error === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got no ready/error in 500 cycles, expected completion", name);
        end
    endtask

    task automatic chk_status(input string name, input logic e_ready, input logic e_busy,
                              input logic e_error, input logic [1:0] e_code);
        chk({name, "_ready"},    {31'd0, ready},    {31'd0, e_ready});
        chk({name, "_busy"},     {31'd0, busy},     {31'd0, e_busy});
        chk({name, "_error"},    {31'd0, error},    {31'd0, e_error});
        chk({name, "_err_code"}, {30'd0, err_code}, {30'd0, e_code});
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_wr_ps2"},   {31'd0, wr_ps2},   32'd0);
        chk({name, "_tx_data"},  {24'd0, tx_data},  32'd0);
        chk({name, "_wheel_en"}, {31'd0, wheel_en}, 32'd0);
        chk_status(name, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int unsigned ts[4];

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Ideal device from auto-start
        run_ideal();
        wait_end("ideal");
        chk_status("ideal", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("ideal_wheel_en", {31'd0, wheel_en}, {31'd0, EXP_WHEEL});

        // Two resends to E8, then ack
        pulse_start();
        chk("restart_ready_clear", {31'd0, ready}, 32'd0);
        serve(8'hFF, 3, 8'hFA, 8'hAA, 8'h00);
        serve(8'hF3, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'h64, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'hE8, 1, 8'hFE, 8'h00, 8'h00);
        serve(8'hE8, 1, 8'hFE, 8'h00, 8'h00);
        serve(8'hE8, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'h02, 1, 8'hFA, 8'h00, 8'h00);
`ifdef PS2_INTELLIMOUSE_EN
        serve(8'hF3, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'hC8, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'hF3, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'h64, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'hF3, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'h50, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'hF2, 2, 8'hFA, 8'h03, 8'h00);
`endif
        serve(8'hF4, 1, 8'hFA, 8'h00, 8'h00);
        wait_end("resend");
        chk_status("resend", 1'b1, 1'b0, 1'b0, 2'b00);

        // Silent device after F3: four sends, then timeout error
        pulse_start();
        serve(8'hFF, 3, 8'hFA, 8'hAA, 8'h00);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hF3);
            wait_wr(ts[i]);
            pulse_tx_done();
        end
        // send-to-resend spacing: TXD to tx_done, ACK_CYC in WAIT_ACK, SEND and WAIT_TX entry
        chk("ack_timeout_interval", ts[1] - ts[0], ACK_CYC + TXD + 2);
        wait_end("timeout");
        chk_status("timeout", 1'b0, 1'b0, 1'b1, 2'b01);

        // Bad BAT, then recovery by start
        pulse_start();
        chk("restart_error_clear", {31'd0, error}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        serve(8'hFF, 2, 8'hFA, 8'hFC, 8'h00);
        wait_end("bad_bat");
        chk_status("bad_bat", 1'b0, 1'b0, 1'b1, 2'b11);
        pulse_start();
        run_ideal();
        wait_end("recover");
        chk_status("recover", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("recover_wheel_en", {31'd0, wheel_en}, {31'd0, EXP_WHEEL});

        // Reset while waiting for the ack to E8
        pulse_start();
        serve(8'hFF, 3, 8'hFA, 8'hAA, 8'h00);
        serve(8'hF3, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'h64, 1, 8'hFA, 8'h00, 8'h00);
        serve(8'hE8, 0, 8'h00, 8'h00, 8'h00);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        repeat (3) @(negedge clk);
        chk_reset_vals("held_reset");
        reset = 1'b0;
        run_ideal();
        wait_end("after_reset");
        chk_status("after_reset", 1'b1, 1'b0, 1'b0, 2'b00);

        repeat (5) @(negedge clk);
        chk("tx_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
